// File: rtl/block_mem_pkg.sv
// Shared types and helpers for block_mem: channel state encoding, default
// geometry and the byte-address to block-index mapping.
package block_mem_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      DONE      = 2'd2,
      WAIT_DROP = 2'd3
   } ch_state_e;

   localparam int DEF_WORD_W          = 32;
   localparam int DEF_WORDS_PER_BLOCK = 4;
   localparam int DEF_DEPTH_WORDS     = 256;
   localparam int DEF_RD_LATENCY      = 10;
   localparam int DEF_WR_LATENCY      = 10;

   // Drops the intra-block offset and keeps idx_w bits, so addresses wrap
   // modulo the memory size.
   function automatic logic [31:0] blk_index(input logic [31:0] addr,
                                              input int          lsb,
                                              input int          idx_w);
      return (addr >> lsb) & ((32'd1 << idx_w) - 32'd1);
   endfunction

endpackage

// File: rtl/block_mem_channel.sv
// One request channel of block_mem: IDLE/BUSY/DONE/WAIT_DROP FSM, latency
// counter and capture of the request payload at acceptance.
module block_mem_channel
   import block_mem_pkg::*;
#(
   parameter int LATENCY   = 10,
   parameter int CNT_W     = 4,
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 req,
   input  logic [PAYLOAD_W-1:0] payload,
   output logic [PAYLOAD_W-1:0] payload_q,
   output logic                 access,
   output logic                 pulse,
   output logic                 busy,
   output ch_state_e            state
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

   ch_state_e        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             capture;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         payload_q <= '0;
      end else if (capture) begin
         cnt       <= '0;
         payload_q <= payload;
      end else if (state == BUSY) begin
         cnt <= cnt + 1'b1;
      end
   end

   // A request still held after completion parks in WAIT_DROP so it is
   // never accepted twice.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      access    = 1'b0;
      pulse     = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               capture   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               access    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            pulse     = 1'b1;
            state_nxt = req ? WAIT_DROP : IDLE;
         end
         WAIT_DROP: begin
            if (!req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/block_mem.sv
// Fixed-latency block-granular backing memory with independent read and
// write channels. Define BLOCK_MEM_RAW_FWD_EN for write-before-read on a
// same-block, same-edge collision; otherwise the read sees old contents.
module block_mem
   import block_mem_pkg::*;
#(
   parameter int WORD_W          = DEF_WORD_W,
   parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
   parameter int DEPTH_WORDS     = DEF_DEPTH_WORDS,
   parameter int RD_LATENCY      = DEF_RD_LATENCY,
   parameter int WR_LATENCY      = DEF_WR_LATENCY
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              read,
   input  logic [31:0]                       read_address,
   output logic [WORD_W*WORDS_PER_BLOCK-1:0] read_data,
   output logic                              read_valid,
   output logic                              read_busy,
   input  logic                              write,
   input  logic [31:0]                       write_address,
   input  logic [WORD_W*WORDS_PER_BLOCK-1:0] write_data,
   output logic                              write_done,
   output logic                              write_busy
);

   localparam int BLK_W      = WORD_W * WORDS_PER_BLOCK;
   localparam int NUM_BLOCKS = DEPTH_WORDS / WORDS_PER_BLOCK;
   localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int BLK_LSB    = $clog2(WORDS_PER_BLOCK * WORD_W / 8);
   localparam int MAX_LAT    = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W      = $clog2(MAX_LAT + 1);

   logic [31:0]      rd_blk_full, wr_blk_full;
   logic [IDX_W-1:0] rd_idx_q, wr_idx_q;
   logic [BLK_W-1:0] wr_data_q, rd_block;
   logic             rd_access, wr_access;
   ch_state_e        rd_state, wr_state;

   // Contents start at zero and are deliberately untouched by reset_n.
   logic [BLK_W-1:0] mem [NUM_BLOCKS] = '{default: '0};

   assign rd_blk_full = blk_index(read_address, BLK_LSB, IDX_W);
   assign wr_blk_full = blk_index(write_address, BLK_LSB, IDX_W);

   block_mem_channel #(
      .LATENCY   (RD_LATENCY),
      .CNT_W     (CNT_W),
      .PAYLOAD_W (IDX_W)
   ) u_rd_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (read),
      .payload   (rd_blk_full[IDX_W-1:0]),
      .payload_q (rd_idx_q),
      .access    (rd_access),
      .pulse     (read_valid),
      .busy      (read_busy),
      .state     (rd_state)
   );

   block_mem_channel #(
      .LATENCY   (WR_LATENCY),
      .CNT_W     (CNT_W),
      .PAYLOAD_W (BLK_W + IDX_W)
   ) u_wr_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (write),
      .payload   ({write_data, wr_blk_full[IDX_W-1:0]}),
      .payload_q ({wr_data_q, wr_idx_q}),
      .access    (wr_access),
      .pulse     (write_done),
      .busy      (write_busy),
      .state     (wr_state)
   );

`ifdef BLOCK_MEM_RAW_FWD_EN
   assign rd_block = (wr_access && (wr_idx_q == rd_idx_q)) ? wr_data_q : mem[rd_idx_q];
`else
   assign rd_block = mem[rd_idx_q];
`endif

   always_ff @(posedge clock) begin
      if (wr_access) mem[wr_idx_q] <= wr_data_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       read_data <= '0;
      else if (rd_access) read_data <= rd_block;
   end

   // Upper address bits and the state debug taps are intentionally unused.
   logic unused_ok;
   assign unused_ok = ^{rd_blk_full[31:IDX_W], wr_blk_full[31:IDX_W], rd_state, wr_state};

endmodule

// File: tb/tb_block_mem.sv
// Self-checking bench for block_mem: default build plus a second instance
// with RD_LATENCY=1, 8-word blocks and 1024 words, against array models.
module tb_block_mem;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // default-geometry instance
   logic         read = 1'b0, write = 1'b0;
   logic [31:0]  read_address = '0, write_address = '0;
   logic [127:0] read_data, write_data = '0;
   logic         read_valid, read_busy, write_done, write_busy;

   // 8-word / RD_LATENCY=1 instance
   logic         r8 = 1'b0, w8 = 1'b0;
   logic [31:0]  ra8 = '0, wa8 = '0;
   logic [255:0] rd8, wd8 = '0;
   logic         rv8, rb8, wdn8, wb8;

   block_mem dut (
      .clock(clock), .reset_n(reset_n),
      .read(read), .read_address(read_address), .read_data(read_data),
      .read_valid(read_valid), .read_busy(read_busy),
      .write(write), .write_address(write_address), .write_data(write_data),
      .write_done(write_done), .write_busy(write_busy)
   );

   block_mem #(.WORD_W(32), .WORDS_PER_BLOCK(8), .DEPTH_WORDS(1024),
               .RD_LATENCY(1), .WR_LATENCY(10)) dut8 (
      .clock(clock), .reset_n(reset_n),
      .read(r8), .read_address(ra8), .read_data(rd8),
      .read_valid(rv8), .read_busy(rb8),
      .write(w8), .write_address(wa8), .write_data(wd8),
      .write_done(wdn8), .write_busy(wb8)
   );

   // reference contents: 16-byte blocks x 64, and 32-byte blocks x 128
   logic [127:0] model_mem [64];
   logic [255:0] model8 [128];
   logic [255:0] exp_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic int blk(input logic [31:0] a);
      return int'((a / 32'd16) % 32'd64);
   endfunction

   function automatic int blk8(input logic [31:0] a);
      return int'((a / 32'd32) % 32'd128);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_i(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [127:0] data, input bit perturb);
      int cyc;
      write = 1'b1; write_address = addr; write_data = data;
      tick();
      check_b("wr_busy_accept", write_busy, 1'b1);
      if (perturb) begin
         write_address = addr ^ 32'h40;
         write_data    = ~data;
      end
      cyc = 0;
      while (write_done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      check_i("wr_latency", cyc, 10);
      check_b("wr_busy_pulse", write_busy, 1'b1);
      model_mem[blk(addr)] = data;
      repeat (2) begin
         tick();
         check_b("wr_held_no_pulse", write_done, 1'b0);
         check_b("wr_held_not_busy", write_busy, 1'b0);
      end
      write = 1'b0;
      tick();
   endtask

   task automatic do_read(input logic [31:0] addr, input bit perturb);
      int cyc;
      logic [255:0] exp;
      exp_q.push_back(256'(model_mem[blk(addr)]));
      read = 1'b1; read_address = addr;
      tick();
      check_b("rd_busy_accept", read_busy, 1'b1);
      if (perturb) read_address = addr ^ 32'h80;
      cyc = 0;
      while (read_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      check_i("rd_latency", cyc, 10);
      exp = exp_q.pop_front();
      check_w("rd_data", 256'(read_data), exp);
      repeat (2) begin
         tick();
         check_b("rd_held_no_pulse", read_valid, 1'b0);
      end
      check_w("rd_data_hold", 256'(read_data), exp);
      read = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] blk_a, new80, old80;
      logic [31:0]  addr;
      int           cyc;

      for (int i = 0; i < 64; i++)  model_mem[i] = '0;
      for (int i = 0; i < 128; i++) model8[i]    = '0;

      // reset state
      repeat (3) tick();
      check_b("rst_read_valid", read_valid, 1'b0);
      check_b("rst_read_busy",  read_busy,  1'b0);
      check_b("rst_write_done", write_done, 1'b0);
      check_b("rst_write_busy", write_busy, 1'b0);
      check_w("rst_read_data",  256'(read_data), 256'd0);
      check_w("rst_read_data8", rd8, 256'd0);
      reset_n = 1'b1;
      tick();

      // basic write/read with offset and wrap aliasing
      blk_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      do_write(32'h40, blk_a, 1'b0);
      do_read(32'h40, 1'b0);
      do_read(32'h4C, 1'b0);
      do_read(32'h440, 1'b0);

      // changes after acceptance must not affect the operation
      do_read(32'h40, 1'b1);
      do_write(32'h200, {4{32'hA5A5_5A5A}}, 1'b1);
      do_read(32'h200, 1'b0);
      do_read(32'h240, 1'b0);

      // same-block read and write accepted on the same edge
      new80 = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
      old80 = model_mem[blk(32'h80)];
      read = 1'b1; read_address = 32'h80;
      write = 1'b1; write_address = 32'h80; write_data = new80;
      tick();
      cyc = 0;
      while (read_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      check_i("raw_rd_latency", cyc, 10);
      check_b("raw_wr_done_same_cycle", write_done, 1'b1);
`ifdef BLOCK_MEM_RAW_FWD_EN
      check_w("raw_rd_data", 256'(read_data), 256'(new80));
`else
      check_w("raw_rd_data", 256'(read_data), 256'(old80));
`endif
      model_mem[blk(32'h80)] = new80;
      read = 1'b0; write = 1'b0;
      tick();
      do_read(32'h80, 1'b0);

      // reset during a write aborts it without commit
      write = 1'b1; write_address = 32'h100; write_data = {4{32'hFFFF_0000}};
      tick();
      repeat (5) tick();
      #2 reset_n = 1'b0;
      #1;
      check_b("abort_write_busy", write_busy, 1'b0);
      check_b("abort_write_done", write_done, 1'b0);
      check_b("abort_read_busy",  read_busy,  1'b0);
      check_b("abort_read_valid", read_valid, 1'b0);
      check_w("abort_read_data",  256'(read_data), 256'd0);
      write = 1'b0;
      repeat (2) tick();
      check_b("abort_no_done", write_done, 1'b0);
      reset_n = 1'b1;
      tick();
      do_read(32'h100, 1'b0);

      // randomized traffic over a handful of blocks with random upper bits
      for (int it = 0; it < 16; it++) begin
         addr = ($urandom() & 32'hFFFF_FC0F) | (32'($urandom_range(0, 7)) << 4);
         if ($urandom_range(0, 1) == 1)
            do_write(addr, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
         else
            do_read(addr, 1'b0);
      end

      // 8-word, RD_LATENCY=1 instance
      wa8 = 32'h60;
      wd8 = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      w8 = 1'b1;
      tick();
      cyc = 0;
      while (wdn8 !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      check_i("b8_wr_latency", cyc, 10);
      model8[blk8(32'h60)] = wd8;
      w8 = 1'b0;
      tick();
      ra8 = 32'h107C;
      r8 = 1'b1;
      tick();
      check_b("b8_rd_busy", rb8, 1'b1);
      check_b("b8_rd_not_yet", rv8, 1'b0);
      tick();
      check_b("b8_rd_valid_lat1", rv8, 1'b1);
      check_w("b8_rd_data", rd8, model8[blk8(32'h107C)]);
      repeat (3) begin
         tick();
         check_b("b8_held_no_pulse", rv8, 1'b0);
         check_b("b8_held_not_busy", rb8, 1'b0);
      end
      r8 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
